reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
- Writer-side companion of the 16-entry x 16-bit register file: buffers execution results and drives the file's single write port (reg_write_en / reg_write_dest / reg_write_data), one write per cycle.
- Sits between execute/memory result producers and the register file.
- Provides a combinational hazard/forwarding lookup, so operand fetch sees values that are queued but not yet committed.

Parameters:
- DATA_WIDTH, 16, register data width.
- ADDR_WIDTH, 4, register address width (16 registers).
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- res_valid  input  1  producer offers a result.
- res_ready  output  1  queue can accept; a push occurs on an edge where res_valid && res_ready.
- res_dest  input  ADDR_WIDTH  destination register of the offered result.
- res_data  input  DATA_WIDTH  result value.
- stall  input  1  inhibit issuing writes to the register file.
- reg_write_en  output  1  write strobe to the register file.
- reg_write_dest  output  ADDR_WIDTH  write address to the register file.
- reg_write_data  output  DATA_WIDTH  write data to the register file.
- chk_addr  input  ADDR_WIDTH  register address to check for pending writes.
- chk_hit  output  1  a pending write to chk_addr exists.
- chk_data  output  DATA_WIDTH  youngest pending value for chk_addr; 0 when no hit.
- count  output  clog2(DEPTH)+1  entries held in the queue (excludes the output stage).
- idle  output  1  count==0 && !reg_write_en.

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers and count go to 0.
  - reg_write_en, reg_write_dest and reg_write_data go to 0.
  - All queued entries are discarded.
  - res_ready is 0 whenever rst=1; pushes are ignored during reset.
- Queue:
  - Circular FIFO; read and write pointers wrap modulo DEPTH.
  - res_ready = !rst && (count < DEPTH). It depends only on registered count; a same-cycle pop does not open a slot.
- Pop/issue, evaluated at each edge:
  - If !stall && count>0: head entry is popped and loaded into the output registers, and reg_write_en<=1.
  - Otherwise reg_write_en<=0, and reg_write_dest/reg_write_data hold their last values.
  - reg_write_en is a single-cycle pulse per entry; back-to-back pops give consecutive pulses.
- Latency:
  - Result pushed at edge N → earliest reg_write_en=1 between edges N+1 and N+2 → register file commits at edge N+2.
  - No bypass around the FIFO.
- Simultaneous push and pop at one edge: count unchanged, entries stay in order.
- Throughput is one result per cycle sustained.
- Order is strictly FIFO, including repeated writes to the same register.
- Register 0 gets no special handling.
- Forwarding (combinational):
  - Search covers all valid queue entries plus the output stage when reg_write_en=1.
  - The output stage counts as pending because the file commits only at the end of that cycle.
  - On multiple matches, the youngest wins: newest queue entry first, then older entries, then the output stage.
  - No match gives chk_hit=0, chk_data=0.
  - The incoming res_* value is not searched until it is pushed.
- Reset mid-operation: queued and in-flight writes are dropped. reg_write_en is 0 from the reset edge onward, so no partial write is issued.
- Stall:
  - Raising stall does not cancel a write already presented.
  - It only prevents the next pop.
  - Pushes continue until full.

Test Plan:
- Reset: rst=1 for 2 cycles with res_valid=1, res_dest=3, res_data=0x1234 → res_ready=0, count=0, reg_write_en=0 throughout. After release, res_ready=1, idle=1 and no write occurs.
- Single write: push dest=2, data=0x0666 at edge N → reg_write_en=1, reg_write_dest=2, reg_write_data=0x0666 for exactly the cycle after N+1. The register file reads r2=0x0666 after edge N+2, and idle returns to 1.
- Full/backpressure: stall=1, push r1..r4 = 0x1111..0x4444 → count=4, res_ready=0, and a 5th result (r5=0x5555) is held. Drop stall → writes r1,r2,r3,r4,r5 on consecutive cycles in order. r5 is accepted at the edge after the first pop.
- Forwarding: stall=1, push r5=0xAAAA then r5=0xBBBB → chk_addr=5 gives chk_hit=1, chk_data=0xBBBB. chk_addr=6 gives chk_hit=0, chk_data=0. Release stall: while r5=0xAAAA is in the output stage, still 0xBBBB. After both commit, hit=0.
- Streaming: res_valid=1 every cycle for 8 cycles with distinct dest/data → count settles at 1 and reg_write_en stays high 8 consecutive cycles with matching values. res_ready never drops.
- Reset mid-op: stall=1, queue r7=0x0007, r8=0x0008, r9=0x0009, release stall, assert rst one cycle later → at most the r7 write issued before reset. No writes after the reset edge, count=0, idle=1.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: FIFO of results feeding the register-file write port, with youngest-wins forwarding lookup.
module reg_writeback_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic [ADDR_WIDTH-1:0]   res_dest,
  input  logic [DATA_WIDTH-1:0]   res_data,
  input  logic                    stall,
  output logic                    reg_write_en,
  output logic [ADDR_WIDTH-1:0]   reg_write_dest,
  output logic [DATA_WIDTH-1:0]   reg_write_data,
  input  logic [ADDR_WIDTH-1:0]   chk_addr,
  output logic                    chk_hit,
  output logic [DATA_WIDTH-1:0]   chk_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    idle
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] dest_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, idx;
  logic push, pop;
  assign res_ready = !rst && (count < FULL);
  assign push = res_valid && res_ready;
  assign pop = !stall && (count != '0);
  assign idle = (count == '0) && !reg_write_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      reg_write_en <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else begin
      if (push) begin
        dest_q[wr_ptr] <= res_dest;
        data_q[wr_ptr] <= res_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        reg_write_dest <= dest_q[rd_ptr];
        reg_write_data <= data_q[rd_ptr];
      end
      reg_write_en <= pop;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // Output stage is oldest; scanning queue oldest-to-newest lets the youngest match overwrite.
  always_comb begin
    chk_hit = reg_write_en && (reg_write_dest == chk_addr);
    chk_data = chk_hit ? reg_write_data : '0;
    idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (dest_q[idx] == chk_addr)) begin
        chk_hit = 1'b1;
        chk_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed and random stimulus checked against a queue-based model of the writeback queue.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  logic clk, rst, res_valid, res_ready, stall, reg_write_en, chk_hit, idle;
  logic [3:0] res_dest, reg_write_dest, chk_addr;
  logic [15:0] res_data, reg_write_data, chk_data;
  logic [2:0] count;
  int compared = 0, mismatched = 0;
  bit run = 0;

  reg_writeback_queue #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_dest(res_dest), .res_data(res_data), .stall(stall),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
    .reg_write_data(reg_write_data), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .chk_data(chk_data), .count(count), .idle(idle)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] d; logic [15:0] v;} ent_t;
  ent_t mq[$];
  logic m_en = 0;
  logic [3:0] m_dest = 0;
  logic [15:0] m_data = 0;
  logic [15:0] rf [16];

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a plain queue plus a one-entry output stage and a register-file image.
  always @(posedge clk) begin
    bit rdy;
    ent_t e;
    rdy = mq.size() < DEPTH;
    if (m_en) rf[m_dest] = m_data;
    if (rst) begin
      mq.delete();
      m_en = 0;
      m_dest = 0;
      m_data = 0;
    end else begin
      if (!stall && mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1;
        m_dest = e.d;
        m_data = e.v;
      end else m_en = 0;
      if (res_valid && rdy) mq.push_back({res_dest, res_data});
    end
  end

  always @(negedge clk) if (run) begin
    logic e_hit;
    logic [15:0] e_data;
    e_hit = 0;
    e_data = 0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (!e_hit && mq[i].d == chk_addr) begin
        e_hit = 1;
        e_data = mq[i].v;
      end
    if (!e_hit && m_en && m_dest == chk_addr) begin
      e_hit = 1;
      e_data = m_data;
    end
    check("res_ready", res_ready, !rst && mq.size() < DEPTH);
    check("count", count, mq.size());
    check("reg_write_en", reg_write_en, m_en);
    if (m_en) begin
      check("reg_write_dest", reg_write_dest, m_dest);
      check("reg_write_data", reg_write_data, m_data);
    end
    check("chk_hit", chk_hit, e_hit);
    check("chk_data", chk_data, e_data);
    check("idle", idle, mq.size() == 0 && !m_en);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; res_valid = 1; res_dest = 3; res_data = 16'h1234; stall = 0; chk_addr = 0;
    for (int i = 0; i < 16; i++) rf[i] = 0;
    step();
    run = 1;
    step();
    check("rst_count", count, 0);
    check("rst_en", reg_write_en, 0);
    check("rst_ready", res_ready, 0);
    rst = 0; res_valid = 0;
    step();
    check("post_rst_ready", res_ready, 1);
    check("post_rst_idle", idle, 1);
    check("post_rst_en", reg_write_en, 0);
    // single write
    res_valid = 1; res_dest = 2; res_data = 16'h0666;
    step();
    res_valid = 0;
    check("single_count", count, 1);
    check("single_en0", reg_write_en, 0);
    step();
    check("single_en", reg_write_en, 1);
    check("single_dest", reg_write_dest, 2);
    check("single_data", reg_write_data, 16'h0666);
    step();
    check("single_en_off", reg_write_en, 0);
    check("single_rf", rf[2], 16'h0666);
    check("single_idle", idle, 1);
    // full / backpressure
    stall = 1;
    for (int i = 1; i <= 4; i++) begin
      res_valid = 1; res_dest = 4'(i); res_data = 16'(i * 16'h1111);
      step();
    end
    res_dest = 5; res_data = 16'h5555;
    step();
    check("full_count", count, 4);
    check("full_ready", res_ready, 0);
    stall = 0;
    step();
    check("bp_dest1", reg_write_dest, 1);
    step();
    res_valid = 0;
    check("bp_dest2", reg_write_dest, 2);
    for (int i = 3; i <= 5; i++) begin
      step();
      check("bp_en", reg_write_en, 1);
      check("bp_dest", reg_write_dest, 4'(i));
      check("bp_data", reg_write_data, 16'(i * 16'h1111));
    end
    step();
    check("bp_done_idle", idle, 1);
    // forwarding
    stall = 1; res_valid = 1; res_dest = 5; res_data = 16'hAAAA;
    step();
    res_data = 16'hBBBB;
    step();
    res_valid = 0; chk_addr = 5;
    #1;
    check("fwd_hit", chk_hit, 1);
    check("fwd_data", chk_data, 16'hBBBB);
    chk_addr = 6;
    #1;
    check("fwd_miss_hit", chk_hit, 0);
    check("fwd_miss_data", chk_data, 0);
    chk_addr = 5; stall = 0;
    step();
    check("fwd_out_data", reg_write_data, 16'hAAAA);
    check("fwd_young", chk_data, 16'hBBBB);
    step();
    check("fwd_stage_hit", chk_hit, 1);
    check("fwd_stage", chk_data, 16'hBBBB);
    step();
    check("fwd_gone", chk_hit, 0);
    // streaming
    for (int i = 0; i < 8; i++) begin
      res_valid = 1; res_dest = 4'(i + 1); res_data = 16'(16'h0100 * i + 16'h0042);
      step();
      check("stream_ready", res_ready, 1);
      if (i > 0) begin
        check("stream_count", count, 1);
        check("stream_en", reg_write_en, 1);
        check("stream_dest", reg_write_dest, 4'(i));
      end
    end
    res_valid = 0;
    step();
    check("stream_last", reg_write_dest, 8);
    step();
    check("stream_end", reg_write_en, 0);
    // reset mid-operation
    stall = 1;
    for (int i = 7; i <= 9; i++) begin
      res_valid = 1; res_dest = 4'(i); res_data = 16'(i);
      step();
    end
    res_valid = 0; stall = 0;
    step();
    check("mid_r7", reg_write_dest, 7);
    rst = 1;
    step();
    check("mid_en", reg_write_en, 0);
    check("mid_count", count, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_idle", idle, 1);
      check("mid_no_wr", reg_write_en, 0);
    end
    // random
    for (int n = 0; n < 3000; n++) begin
      res_valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 3) == 0;
      res_dest = 4'($urandom_range(0, 15));
      res_data = 16'($urandom);
      chk_addr = 4'($urandom_range(0, 15));
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0; res_valid = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
